video_mnist_detection_param_ctl: RTL and testbench
==================================================

Name: video_mnist_detection_param_ctl

Overview:
Wishbone-programmable parameter controller for the MNIST CNN detection pipeline (binarizer → CNN core / detection core → max-count). Holds a register bank for the binarizer threshold and invert, the CNN blank count and the pipeline enable. It applies a new parameter set atomically at a video frame boundary, detected by snooping the pipeline input AXI4-Stream handshake. A timeout forces the update when no frame arrives.

Parameters:
WB_ADR_WIDTH, 8, wishbone word address width
WB_DAT_WIDTH, 32, wishbone data width
WB_SEL_WIDTH, WB_DAT_WIDTH/8, byte-select width
TUSER_WIDTH, 1, width of the snooped tuser; bit 0 marks start of frame
CORE_ID, 32'h527a_2310, value returned by the ID register
INIT_CTL_ENABLE, 1'b1, reset value of enable
INIT_PARAM_TH, 8'd127, reset binarizer threshold
INIT_PARAM_INV, 1'b0, reset binarizer invert
INIT_PARAM_BLANK_NUM, 8'd3, reset CNN blank count
INIT_TIMEOUT, 32'd0, reset timeout in cycles; 0 = no timeout

Ports:
clk  input  1  system clock; also the wishbone clock
reset  input  1  synchronous, active-high reset
s_wb_adr_i  input  WB_ADR_WIDTH  word address
s_wb_dat_i  input  WB_DAT_WIDTH  write data
s_wb_dat_o  output  WB_DAT_WIDTH  read data
s_wb_we_i  input  1  write enable
s_wb_sel_i  input  WB_SEL_WIDTH  byte enables
s_wb_stb_i  input  1  strobe
s_wb_ack_o  output  1  acknowledge
s_axi4s_tuser  input  TUSER_WIDTH  snooped pipeline input tuser
s_axi4s_tvalid  input  1  snooped tvalid
s_axi4s_tready  input  1  snooped tready
out_enable  output  1  applied pipeline enable
out_param_th  output  8  applied binarizer threshold
out_param_inv  output  1  applied binarizer invert
out_param_blank_num  output  8  applied CNN blank count
out_update  output  1  one-cycle pulse when a new set is applied

Behaviour:
- Reset (clk edge with reset=1):
  - Register bank and applied outputs load the INIT_* values.
  - pending=0, timeout_flag=0, counters=0, out_update=0, state=ST_IDLE.
- Wishbone: s_wb_ack_o = s_wb_stb_i (combinational, zero wait).
  - Writes occur when stb & we, with per-byte sel masking.
  - s_wb_dat_o is combinational from address; unmapped addresses read 0.
- Register map (word address):
  - 0x00 CORE_ID (RO).
  - 0x04 CTL_CONTROL: bit0 enable (RW); bit1 update_req. Writing 1 sets pending; writing 0 has no effect; reads return pending.
  - 0x05 CTL_STATUS: bit0 out_enable; bit1 pending; bit2 timeout_flag (W1C).
  - 0x06 CTL_INDEX (RO): 32-bit count of applied updates, wraps at 2^32.
  - 0x07 FRAME_COUNT (RO): 32-bit count of frame starts, wraps.
  - 0x08 PARAM_TH (RW, bits 7:0).
  - 0x09 PARAM_INV (RW, bit 0).
  - 0x0a PARAM_BLANK_NUM (RW, bits 7:0).
  - 0x0c TIMEOUT (RW, 32 bits).
  - 0x18 / 0x19 / 0x1a: readback of applied th / inv / blank_num (RO).
- frame_start = s_axi4s_tvalid & s_axi4s_tready & s_axi4s_tuser[0].
  - FRAME_COUNT increments on every frame_start, regardless of state.
- States:
  - ST_IDLE: pending=0. Writing update_req=1 → ST_WAIT, pending=1, timer cleared to 0.
  - ST_WAIT: timer increments each cycle while in this state, saturating at all-ones.
    - Leave ST_WAIT on frame_start, or on (TIMEOUT≠0 and timer+1 ≥ TIMEOUT).
    - On leaving: copy enable/th/inv/blank_num to the outputs at the next edge, pulse out_update for 1 cycle, increment CTL_INDEX, clear pending, → ST_IDLE.
    - A timeout exit also sets timeout_flag.
- Latency: the apply edge is the edge sampling frame_start. Outputs change on that same edge, i.e. they are valid in the first cycle after the SOF beat.
- Simultaneous events:
  - update_req write in the same cycle as a frame_start: the request becomes pending; it is not applied by that frame_start.
  - Bank write in the same cycle as an apply: the apply copies the pre-write value; the new value waits for the next request.
  - update_req write while already pending: no effect; the timer is not restarted.
  - frame_start and timeout in the same cycle: apply once; timeout_flag is not set (the frame wins).
  - W1C of timeout_flag in the same cycle as a timeout set: the set wins.
- Reset mid-ST_WAIT: the pending request is discarded and outputs revert to INIT_* values.

Test Plan:
- Reset, then read 0x00 / 0x08 / 0x0a / 0x18 → 32'h527a_2310 / 127 / 3 / 127; out_param_th=127, out_param_blank_num=3, out_enable=1.
- Write PARAM_TH=0x40 with no update_req, then drive 3 frame_starts → out_param_th stays 127, FRAME_COUNT=3, CTL_INDEX=0.
- Write PARAM_TH=0x40 and BLANK_NUM=5, then update_req=1, then a frame_start 10 cycles later → STATUS bit1=1 until the SOF; outputs 0x40/5 valid the cycle after the SOF beat; out_update pulses once; CTL_INDEX=1.
- TIMEOUT=20 with no frames, then update_req → apply after 20 cycles; STATUS bit2=1; a W1C write to 0x05 clears it.
- update_req written in the same cycle as a frame_start → not applied; applied on the following SOF.
- Byte-select write of 0x0000_00AA to PARAM_TH with sel=4'b0010 → PARAM_TH unchanged (127).
- reset asserted while pending → pending=0, outputs return to INIT_* values, and no out_update pulse occurs.

Source files
------------

// File: rtl/video_mnist_detection_param_ctl.sv
// Wishbone parameter bank for the MNIST detection pipeline. Staged parameters are
// copied to the outputs in one step at a frame start, or when the request times out.
module video_mnist_detection_param_ctl #(
  parameter int unsigned WB_ADR_WIDTH         = 8,
  parameter int unsigned WB_DAT_WIDTH         = 32,
  parameter int unsigned WB_SEL_WIDTH         = WB_DAT_WIDTH / 8,
  parameter int unsigned TUSER_WIDTH          = 1,
  parameter logic [31:0] CORE_ID              = 32'h527a_2310,
  parameter logic        INIT_CTL_ENABLE      = 1'b1,
  parameter logic [7:0]  INIT_PARAM_TH        = 8'd127,
  parameter logic        INIT_PARAM_INV       = 1'b0,
  parameter logic [7:0]  INIT_PARAM_BLANK_NUM = 8'd3,
  parameter logic [31:0] INIT_TIMEOUT         = 32'd0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [WB_ADR_WIDTH-1:0] s_wb_adr_i,
  input  logic [WB_DAT_WIDTH-1:0] s_wb_dat_i,
  output logic [WB_DAT_WIDTH-1:0] s_wb_dat_o,
  input  logic                    s_wb_we_i,
  input  logic [WB_SEL_WIDTH-1:0] s_wb_sel_i,
  input  logic                    s_wb_stb_i,
  output logic                    s_wb_ack_o,
  input  logic [TUSER_WIDTH-1:0]  s_axi4s_tuser,
  input  logic                    s_axi4s_tvalid,
  input  logic                    s_axi4s_tready,
  output logic                    out_enable,
  output logic [7:0]              out_param_th,
  output logic                    out_param_inv,
  output logic [7:0]              out_param_blank_num,
  output logic                    out_update
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  localparam logic [WB_ADR_WIDTH-1:0] ADR_CORE_ID   = WB_ADR_WIDTH'(8'h00);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_CONTROL   = WB_ADR_WIDTH'(8'h04);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_STATUS    = WB_ADR_WIDTH'(8'h05);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_INDEX     = WB_ADR_WIDTH'(8'h06);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_FRAME_CNT = WB_ADR_WIDTH'(8'h07);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_TH        = WB_ADR_WIDTH'(8'h08);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_INV       = WB_ADR_WIDTH'(8'h09);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_BLANK     = WB_ADR_WIDTH'(8'h0a);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_TIMEOUT   = WB_ADR_WIDTH'(8'h0c);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_OUT_TH    = WB_ADR_WIDTH'(8'h18);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_OUT_INV   = WB_ADR_WIDTH'(8'h19);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_OUT_BLANK = WB_ADR_WIDTH'(8'h1a);

  state_t      state_q;
  logic        enable_q, inv_q, timeout_flag_q;
  logic [7:0]  th_q, blank_q;
  logic [31:0] timeout_q, timer_q, index_q, frame_cnt_q;
  logic        out_enable_q, out_inv_q, out_update_q;
  logic [7:0]  out_th_q, out_blank_q;

  logic [WB_DAT_WIDTH-1:0] wmask, rdata;
  logic        enable_d, inv_d;
  logic [7:0]  th_d, blank_d;
  logic [31:0] timeout_d;
  logic        wr_en, update_req, timeout_clr, frame_start, pending;
  logic        timeout_hit, apply, timeout_set;
  logic [32:0] timer_inc;

  assign wr_en       = s_wb_stb_i & s_wb_we_i;
  assign frame_start = s_axi4s_tvalid & s_axi4s_tready & s_axi4s_tuser[0];
  assign pending     = (state_q == ST_WAIT);

  // The 33-bit sum keeps the compare correct when the timer sits at all-ones.
  assign timer_inc   = {1'b0, timer_q} + 33'd1;
  assign timeout_hit = (timeout_q != 32'd0) && (timer_inc >= {1'b0, timeout_q});
  assign apply       = pending && (frame_start || timeout_hit);
  assign timeout_set = pending && !frame_start && timeout_hit;

  assign update_req  = wr_en && (s_wb_adr_i == ADR_CONTROL) && wmask[1] && s_wb_dat_i[1];
  assign timeout_clr = wr_en && (s_wb_adr_i == ADR_STATUS) && wmask[2] && s_wb_dat_i[2];

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    wmask     = '0;
    enable_d  = enable_q;
    th_d      = th_q;
    inv_d     = inv_q;
    blank_d   = blank_q;
    timeout_d = timeout_q;
    for (int i = 0; i < int'(WB_DAT_WIDTH); i++) wmask[i] = s_wb_sel_i[i / 8];
    if (wr_en) begin
      case (s_wb_adr_i)
        ADR_CONTROL: enable_d  = (enable_q & ~wmask[0]) | (s_wb_dat_i[0] & wmask[0]);
        ADR_TH:      th_d      = (th_q & ~wmask[7:0]) | (s_wb_dat_i[7:0] & wmask[7:0]);
        ADR_INV:     inv_d     = (inv_q & ~wmask[0]) | (s_wb_dat_i[0] & wmask[0]);
        ADR_BLANK:   blank_d   = (blank_q & ~wmask[7:0]) | (s_wb_dat_i[7:0] & wmask[7:0]);
        ADR_TIMEOUT: timeout_d = (timeout_q & ~wmask[31:0]) | (s_wb_dat_i[31:0] & wmask[31:0]);
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    case (s_wb_adr_i)
      ADR_CORE_ID:   rdata = WB_DAT_WIDTH'(CORE_ID);
      ADR_CONTROL:   rdata[1:0] = {pending, enable_q};
      ADR_STATUS:    rdata[2:0] = {timeout_flag_q, pending, out_enable_q};
      ADR_INDEX:     rdata = WB_DAT_WIDTH'(index_q);
      ADR_FRAME_CNT: rdata = WB_DAT_WIDTH'(frame_cnt_q);
      ADR_TH:        rdata[7:0] = th_q;
      ADR_INV:       rdata[0] = inv_q;
      ADR_BLANK:     rdata[7:0] = blank_q;
      ADR_TIMEOUT:   rdata = WB_DAT_WIDTH'(timeout_q);
      ADR_OUT_TH:    rdata[7:0] = out_th_q;
      ADR_OUT_INV:   rdata[0] = out_inv_q;
      ADR_OUT_BLANK: rdata[7:0] = out_blank_q;
      default: ;
    endcase
  end

  // NOTE: all state below updates with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      enable_q       <= INIT_CTL_ENABLE;
      th_q           <= INIT_PARAM_TH;
      inv_q          <= INIT_PARAM_INV;
      blank_q        <= INIT_PARAM_BLANK_NUM;
      timeout_q      <= INIT_TIMEOUT;
      timer_q        <= 32'd0;
      index_q        <= 32'd0;
      frame_cnt_q    <= 32'd0;
      timeout_flag_q <= 1'b0;
      out_enable_q   <= INIT_CTL_ENABLE;
      out_th_q       <= INIT_PARAM_TH;
      out_inv_q      <= INIT_PARAM_INV;
      out_blank_q    <= INIT_PARAM_BLANK_NUM;
      out_update_q   <= 1'b0;
    end else begin
      enable_q       <= enable_d;
      th_q           <= th_d;
      inv_q          <= inv_d;
      blank_q        <= blank_d;
      timeout_q      <= timeout_d;
      out_update_q   <= apply;
      timeout_flag_q <= timeout_set | (timeout_flag_q & ~timeout_clr);
      if (frame_start) frame_cnt_q <= frame_cnt_q + 32'd1;
      case (state_q)
        ST_IDLE: begin
          if (update_req) begin
            state_q <= ST_WAIT;
            timer_q <= 32'd0;
          end
        end
        ST_WAIT: begin
          if (timer_q != 32'hffff_ffff) timer_q <= timer_q + 32'd1;
          // Outputs take the bank as it stood before this edge's bus write.
          if (apply) begin
            out_enable_q <= enable_q;
            out_th_q     <= th_q;
            out_inv_q    <= inv_q;
            out_blank_q  <= blank_q;
            index_q      <= index_q + 32'd1;
            state_q      <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign s_wb_ack_o          = s_wb_stb_i;
  assign s_wb_dat_o          = rdata;
  assign out_enable          = out_enable_q;
  assign out_param_th        = out_th_q;
  assign out_param_inv       = out_inv_q;
  assign out_param_blank_num = out_blank_q;
  assign out_update          = out_update_q;

endmodule

// File: tb/tb_video_mnist_detection_param_ctl.sv
// Scoreboard bench: stimulus queues expected bus reads and parameter updates,
// a negedge monitor pops and compares them whenever the DUT presents a response.
module tb_video_mnist_detection_param_ctl;

  typedef struct {
    string       name;
    logic [31:0] val;
  } rd_t;

  typedef struct {
    int         cyc;
    logic [7:0] th;
    logic       inv;
    logic [7:0] blank;
    logic       en;
  } upd_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  wb_adr;
  logic [31:0] wb_dat, wb_rdat;
  logic        wb_we, wb_stb, wb_ack;
  logic [3:0]  wb_sel;
  logic [0:0]  tuser;
  logic        tvalid, tready;
  logic        out_enable, out_param_inv, out_update;
  logic [7:0]  out_param_th, out_param_blank_num;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  rd_t  exp_rd[$];
  upd_t exp_upd[$];
  rd_t  cur_rd;
  upd_t cur_upd;
  int   c;

  video_mnist_detection_param_ctl dut (
    .clk                (clk),
    .reset              (reset),
    .s_wb_adr_i         (wb_adr),
    .s_wb_dat_i         (wb_dat),
    .s_wb_dat_o         (wb_rdat),
    .s_wb_we_i          (wb_we),
    .s_wb_sel_i         (wb_sel),
    .s_wb_stb_i         (wb_stb),
    .s_wb_ack_o         (wb_ack),
    .s_axi4s_tuser      (tuser),
    .s_axi4s_tvalid     (tvalid),
    .s_axi4s_tready     (tready),
    .out_enable         (out_enable),
    .out_param_th       (out_param_th),
    .out_param_inv      (out_param_inv),
    .out_param_blank_num(out_param_blank_num),
    .out_update         (out_update)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: bus reads and update pulses are compared against the queued expectations.
  always @(negedge clk) begin
    if (wb_stb) check("wb_ack", {31'd0, wb_ack}, 32'd1);
    if (wb_stb && !wb_we) begin
      if (exp_rd.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_read: got 0x%08h with no expectation queued", wb_rdat);
      end else begin
        cur_rd = exp_rd.pop_front();
        check(cur_rd.name, wb_rdat, cur_rd.val);
      end
    end
    if (out_update) begin
      if (exp_upd.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_update: pulse at cycle %0d, none expected", cyc);
      end else begin
        cur_upd = exp_upd.pop_front();
        check("upd_cycle", cyc, cur_upd.cyc);
        check("upd_th", {24'd0, out_param_th}, {24'd0, cur_upd.th});
        check("upd_inv", {31'd0, out_param_inv}, {31'd0, cur_upd.inv});
        check("upd_blank", {24'd0, out_param_blank_num}, {24'd0, cur_upd.blank});
        check("upd_en", {31'd0, out_enable}, {31'd0, cur_upd.en});
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [7:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    wb_adr = adr; wb_dat = dat; wb_sel = sel; wb_we = 1'b1; wb_stb = 1'b1;
    idle(1);
    wb_stb = 1'b0; wb_we = 1'b0;
  endtask

  task automatic wb_read(input logic [7:0] adr, input logic [31:0] exp, input string name);
    rd_t e;
    e.name = name;
    e.val  = exp;
    exp_rd.push_back(e);
    wb_adr = adr; wb_we = 1'b0; wb_stb = 1'b1;
    idle(1);
    wb_stb = 1'b0;
  endtask

  task automatic sof();
    tvalid = 1'b1; tready = 1'b1; tuser = 1'b1;
    idle(1);
    tvalid = 1'b0; tready = 1'b0; tuser = 1'b0;
  endtask

  task automatic expect_update(input int at, input logic [7:0] th, input logic inv,
                               input logic [7:0] blank, input logic en);
    upd_t u;
    u.cyc = at; u.th = th; u.inv = inv; u.blank = blank; u.en = en;
    exp_upd.push_back(u);
  endtask

  task automatic check_init_outputs(input string tag);
    check({tag, "_out_th"}, {24'd0, out_param_th}, 32'd127);
    check({tag, "_out_blank"}, {24'd0, out_param_blank_num}, 32'd3);
    check({tag, "_out_inv"}, {31'd0, out_param_inv}, 32'd0);
    check({tag, "_out_en"}, {31'd0, out_enable}, 32'd1);
  endtask

  initial begin
    reset = 1'b1; wb_adr = '0; wb_dat = '0; wb_sel = '0; wb_we = 1'b0; wb_stb = 1'b0;
    tuser = 1'b0; tvalid = 1'b0; tready = 1'b0;
    idle(3);
    reset = 1'b0;

    // Reset values and register map
    check_init_outputs("rst");
    check("rst_out_update", {31'd0, out_update}, 32'd0);
    wb_read(8'h00, 32'h527a_2310, "rd_core_id");
    wb_read(8'h08, 32'd127, "rd_th_init");
    wb_read(8'h0a, 32'd3, "rd_blank_init");
    wb_read(8'h18, 32'd127, "rd_out_th_init");
    wb_read(8'h05, 32'd1, "rd_status_init");
    wb_read(8'h04, 32'd1, "rd_control_init");
    wb_read(8'h0c, 32'd0, "rd_timeout_init");
    wb_read(8'h33, 32'd0, "rd_unmapped");

    // Byte lane 1 does not reach the 8-bit threshold
    wb_write(8'h08, 32'h0000_00aa, 4'b0010);
    wb_read(8'h08, 32'd127, "rd_th_sel_masked");

    // Frames without a request apply nothing; a tvalid-only beat is not a frame
    wb_write(8'h08, 32'h40, 4'hf);
    sof(); idle(2); sof(); idle(1);
    tvalid = 1'b1; tuser = 1'b1; idle(1); tvalid = 1'b0; tuser = 1'b0;
    sof(); idle(2);
    check("no_req_out_th", {24'd0, out_param_th}, 32'd127);
    wb_read(8'h07, 32'd3, "rd_frame_cnt_3");
    wb_read(8'h06, 32'd0, "rd_index_0");
    wb_read(8'h08, 32'h40, "rd_th_staged");
    wb_read(8'h18, 32'd127, "rd_out_th_unchanged");

    // Request applied at the next SOF
    wb_write(8'h0a, 32'd5, 4'hf);
    wb_write(8'h04, 32'h3, 4'hf);
    wb_read(8'h05, 32'd3, "rd_status_pending");
    idle(8);
    wb_read(8'h05, 32'd3, "rd_status_still_pending");
    c = cyc; expect_update(c + 1, 8'h40, 1'b0, 8'd5, 1'b1);
    sof();
    wb_read(8'h06, 32'd1, "rd_index_1");
    wb_read(8'h05, 32'd1, "rd_status_applied");
    wb_read(8'h18, 32'h40, "rd_out_th_40");
    wb_read(8'h1a, 32'd5, "rd_out_blank_5");
    wb_read(8'h19, 32'd0, "rd_out_inv_0");

    // Timeout of 20 cycles with no frames
    wb_write(8'h08, 32'h22, 4'hf);
    wb_write(8'h0c, 32'd20, 4'hf);
    c = cyc; expect_update(c + 21, 8'h22, 1'b0, 8'd5, 1'b1);
    wb_write(8'h04, 32'h3, 4'hf);
    idle(10);
    wb_read(8'h05, 32'd3, "rd_status_wait_timeout");
    idle(15);
    wb_read(8'h05, 32'd5, "rd_status_timeout_flag");
    wb_read(8'h06, 32'd2, "rd_index_2");
    wb_write(8'h05, 32'h4, 4'hf);
    wb_read(8'h05, 32'd1, "rd_status_w1c");
    wb_write(8'h0c, 32'd0, 4'hf);

    // Request written in the same cycle as a SOF waits for the following SOF
    wb_write(8'h09, 32'd1, 4'hf);
    wb_write(8'h08, 32'h55, 4'hf);
    wb_adr = 8'h04; wb_dat = 32'h3; wb_sel = 4'hf; wb_we = 1'b1; wb_stb = 1'b1;
    tvalid = 1'b1; tready = 1'b1; tuser = 1'b1;
    idle(1);
    wb_stb = 1'b0; wb_we = 1'b0; tvalid = 1'b0; tready = 1'b0; tuser = 1'b0;
    wb_read(8'h05, 32'd3, "rd_status_same_cycle_req");
    check("same_cycle_out_th", {24'd0, out_param_th}, 32'h22);
    idle(3);
    c = cyc; expect_update(c + 1, 8'h55, 1'b1, 8'd5, 1'b1);
    sof();
    wb_read(8'h07, 32'd6, "rd_frame_cnt_6");

    // Bank write on the apply edge: the old value is applied
    wb_write(8'h08, 32'h66, 4'hf);
    wb_write(8'h04, 32'h3, 4'hf);
    idle(2);
    c = cyc; expect_update(c + 1, 8'h66, 1'b1, 8'd5, 1'b1);
    wb_adr = 8'h08; wb_dat = 32'h77; wb_sel = 4'hf; wb_we = 1'b1; wb_stb = 1'b1;
    tvalid = 1'b1; tready = 1'b1; tuser = 1'b1;
    idle(1);
    wb_stb = 1'b0; wb_we = 1'b0; tvalid = 1'b0; tready = 1'b0; tuser = 1'b0;
    wb_read(8'h08, 32'h77, "rd_th_after_race");
    wb_read(8'h18, 32'h66, "rd_out_th_pre_write");
    wb_read(8'h19, 32'd1, "rd_out_inv_1");

    // SOF and timeout together: one apply, no timeout flag; enable cleared
    wb_write(8'h0c, 32'd5, 4'hf);
    c = cyc; expect_update(c + 6, 8'h77, 1'b1, 8'd5, 1'b0);
    wb_write(8'h04, 32'h2, 4'hf);
    idle(4);
    sof();
    idle(2);
    wb_read(8'h05, 32'd0, "rd_status_tie");
    wb_read(8'h04, 32'd0, "rd_control_disabled");
    wb_read(8'h07, 32'd8, "rd_frame_cnt_8");
    wb_read(8'h06, 32'd5, "rd_index_5");
    wb_write(8'h0c, 32'd0, 4'hf);

    // Reset while pending discards the request
    wb_write(8'h08, 32'h99, 4'hf);
    wb_write(8'h04, 32'h3, 4'hf);
    wb_read(8'h05, 32'd2, "rd_status_pending_pre_reset");
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    check_init_outputs("rst2");
    wb_read(8'h05, 32'd1, "rd_status_post_reset");
    wb_read(8'h04, 32'd1, "rd_control_post_reset");
    wb_read(8'h08, 32'd127, "rd_th_post_reset");
    wb_read(8'h06, 32'd0, "rd_index_post_reset");
    wb_read(8'h07, 32'd0, "rd_frame_cnt_post_reset");
    sof();
    idle(5);
    wb_read(8'h07, 32'd1, "rd_frame_cnt_after_reset_sof");
    check("rst2_out_th_after_sof", {24'd0, out_param_th}, 32'd127);

    for (int i = 0; i < 50 && (exp_upd.size() != 0 || exp_rd.size() != 0); i++) idle(1);
    check("pending_updates", exp_upd.size(), 32'd0);
    check("pending_reads", exp_rd.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
